// File: rtl/banner_reveal_ctrl.sv
// Frame-locked banner sequencer: typewriter reveal of N_CHARS glyph slots,
// a blink phase over the whole banner, then a steady hold until restart/abort.
module banner_reveal_ctrl #(
    parameter int unsigned N_CHARS       = 6,
    parameter int unsigned REVEAL_FRAMES = 8,
    parameter int unsigned BLINK_FRAMES  = 15,
    parameter int unsigned BLINK_TOGGLES = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               abort,
    output logic [N_CHARS-1:0] en_vec,
    output logic [3:0]         reveal_cnt,
    output logic               busy,
    output logic               done
);
    localparam int unsigned      CNT_W       = 8;
    localparam logic [CNT_W-1:0] REVEAL_LAST = CNT_W'(REVEAL_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] TOGGLE_END  = CNT_W'(BLINK_TOGGLES);
    localparam logic [3:0]       CHARS_END   = 4'(N_CHARS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REVEAL = 2'd1,
        BLINK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   toggle_cnt;
    logic               visible;
    logic [3:0]         reveal_next;
    logic [CNT_W-1:0]   toggle_next;
    logic [N_CHARS-1:0] reveal_mask;

    // Next counter values and the enable pattern for the next reveal count
    always_comb begin
        reveal_next = reveal_cnt + 4'd1;
        toggle_next = toggle_cnt + CNT_W'(1);
        reveal_mask = '0;
        for (int k = 0; k < int'(N_CHARS); k++) begin
            reveal_mask[k] = (4'(k) < reveal_next);
        end
    end

    // Sequencer: abort beats start beats frame_tick; en_vec only moves on those events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            en_vec     <= '0;
            reveal_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            visible    <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            en_vec     <= '0;
            reveal_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            visible    <= 1'b0;
        end else if (start && (state == IDLE || state == DONE)) begin
            state      <= REVEAL;
            en_vec     <= '0;
            reveal_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            visible    <= 1'b0;
        end else if (frame_tick) begin
            case (state)
                REVEAL: begin
                    if (frame_cnt == REVEAL_LAST) begin
                        frame_cnt  <= '0;
                        reveal_cnt <= reveal_next;
                        if (reveal_next == CHARS_END) begin
                            state      <= BLINK;
                            visible    <= 1'b1;
                            toggle_cnt <= '0;
                            en_vec     <= '1;
                        end else begin
                            en_vec <= reveal_mask;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                BLINK: begin
                    if (frame_cnt == BLINK_LAST) begin
                        frame_cnt  <= '0;
                        visible    <= !visible;
                        toggle_cnt <= toggle_next;
                        if (toggle_next == TOGGLE_END) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            en_vec <= '1;
                        end else begin
                            // visible is about to flip, so drive the new phase
                            en_vec <= visible ? '0 : '1;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
